// File: rtl/wide_fetch_if.sv
// wide_fetch_if: memory-side read port and instruction-queue dequeue port of the wide fetch unit.
interface wide_fetch_if #(
    parameter int unsigned FETCH_WIDTH = 2
);
    logic [31:0]               ufp_addr;
    logic [4*FETCH_WIDTH-1:0]  ufp_rmask;
    logic [4*FETCH_WIDTH-1:0]  ufp_wmask;
    logic [32*FETCH_WIDTH-1:0] ufp_wdata;
    logic [32*FETCH_WIDTH-1:0] ufp_rdata;
    logic                      ufp_resp;
    logic                      dequeue;
    logic                      is_empty;
    logic [31:0]               dequeue_pc;
    logic [32*FETCH_WIDTH-1:0] dequeue_inst;
    logic [FETCH_WIDTH-1:0]    dequeue_valid;
    logic                      flush;
    logic [31:0]               pc_new;

    // Fetch unit side.
    modport master (
        output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        input  ufp_rdata, ufp_resp,
        input  dequeue, flush, pc_new,
        output is_empty, dequeue_pc, dequeue_inst, dequeue_valid
    );

    // Memory / decode side.
    modport slave (
        input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata,
        output ufp_rdata, ufp_resp,
        output dequeue, flush, pc_new,
        input  is_empty, dequeue_pc, dequeue_inst, dequeue_valid
    );
endinterface

// File: rtl/wide_fetch.sv
// wide_fetch: fetches FETCH_WIDTH-instruction blocks into a QUEUE_DEPTH-entry queue.
// Optional macro FETCH_HOLD_EN: issue even when full; a response that finds the
// queue full is parked in a hold register (WAIT state) until space frees up.
module wide_fetch #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned QUEUE_DEPTH = 16,
    parameter logic [31:0] PC_RESET    = 32'h1ECEB000
) (
    input  logic         clk,
    input  logic         rst,
    wide_fetch_if.master bus
);
    localparam int unsigned BLK_BYTES  = 4 * FETCH_WIDTH;
    localparam int unsigned INST_W     = 32 * FETCH_WIDTH;
    localparam int unsigned MASK_W     = 4 * FETCH_WIDTH;
    localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam logic [31:0] ALIGN_MASK = ~32'(BLK_BYTES - 1);
    localparam logic [31:0] LANE_MASK  = 32'(FETCH_WIDTH - 1);

    typedef struct packed {
        logic [31:0]            pc;
        logic [INST_W-1:0]      inst;
        logic [FETCH_WIDTH-1:0] valid;
    } entry_t;

`ifdef FETCH_HOLD_EN
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
`endif

    state_t           state, state_nx;
    logic [31:0]      pc_r, pc_aligned, lane_off;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head, tail;
    entry_t           mem [QUEUE_DEPTH];
    entry_t           new_entry, enq_entry;
    logic             full, empty, deq, enq, pc_adv, issue_c, issue_ok;
`ifdef FETCH_HOLD_EN
    entry_t           hold_q;
    logic             hold_load;
`endif

    assign pc_aligned = pc_r & ALIGN_MASK;
    assign full       = (count == CNT_W'(QUEUE_DEPTH));
    assign empty      = (count == '0);
    assign deq        = bus.dequeue && !empty && !bus.flush;

`ifdef FETCH_HOLD_EN
    assign issue_ok = 1'b1;
`else
    assign issue_ok = !full;
`endif

    // Build the entry for an arriving block; lanes below the PC's lane are invalid.
    always_comb begin
        lane_off        = (pc_r >> 2) & LANE_MASK;
        new_entry.pc    = pc_aligned;
        new_entry.inst  = bus.ufp_rdata;
        new_entry.valid = '0;
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            new_entry.valid[i] = (32'(i) >= lane_off);
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nx  = state;
        issue_c   = 1'b0;
        enq       = 1'b0;
        enq_entry = new_entry;
        pc_adv    = 1'b0;
`ifdef FETCH_HOLD_EN
        hold_load = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!bus.flush && issue_ok) begin
                    issue_c  = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (bus.ufp_resp) begin
                    state_nx = IDLE;
                    if (!bus.flush) begin
                        pc_adv = 1'b1;
                        if (!full) begin
                            enq = 1'b1;
                        end
`ifdef FETCH_HOLD_EN
                        else begin
                            hold_load = 1'b1;
                            state_nx  = WAIT;
                        end
`endif
                    end
                end else if (bus.flush) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.ufp_resp) begin
                    state_nx = IDLE;
                end
            end
`ifdef FETCH_HOLD_EN
            WAIT: begin
                if (bus.flush) begin
                    state_nx = IDLE;
                end else if (!full) begin
                    enq       = 1'b1;
                    enq_entry = hold_q;
                    state_nx  = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            state_nx = IDLE;
            issue_c  = 1'b0;
            enq      = 1'b0;
            pc_adv   = 1'b0;
`ifdef FETCH_HOLD_EN
            hold_load = 1'b0;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // PC, queue pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r  <= PC_RESET;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (bus.flush) begin
            pc_r  <= bus.pc_new;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (pc_adv) begin
                pc_r <= pc_aligned + 32'(BLK_BYTES);
            end
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Queue storage write.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= enq_entry;
        end
    end

`ifdef FETCH_HOLD_EN
    // Hold register for a block that arrived while the queue was full.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            hold_q <= '0;
        end else if (hold_load) begin
            hold_q <= new_entry;
        end
    end
`endif

    assign bus.ufp_addr      = pc_aligned;
    assign bus.ufp_rmask     = {MASK_W{issue_c}};
    assign bus.ufp_wmask     = '0;
    assign bus.ufp_wdata     = '0;
    assign bus.is_empty      = rst | empty;
    assign bus.dequeue_pc    = mem[head].pc;
    assign bus.dequeue_inst  = mem[head].inst;
    assign bus.dequeue_valid = mem[head].valid;
endmodule

// File: doc/wide_fetch.md
WIDE_FETCH -- requirements
Module: wide_fetch

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, instructions per fetch block (legal values 1, 2, 4).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 16, number of queue entries (power of two, at least 4).
REQ-003 SHALL have parameter PC_RESET, default 32'h1ECEB000, PC after reset.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port ufp_addr, output, 32 bits, block-aligned fetch address.
REQ-007 SHALL have port ufp_rmask, output, 4*FETCH_WIDTH bits, read request strobe.
REQ-008 SHALL have port ufp_wmask, output, 4*FETCH_WIDTH bits, tied to 0.
REQ-009 SHALL have port ufp_wdata, output, 32*FETCH_WIDTH bits, tied to 0.
REQ-010 SHALL have port ufp_rdata, input, 32*FETCH_WIDTH bits, fetch block data, lane 0 in the LSBs.
REQ-011 SHALL have port ufp_resp, input, 1 bit, read response valid.
REQ-012 SHALL have port dequeue, input, 1 bit, pop the head entry.
REQ-013 SHALL have port is_empty, output, 1 bit, queue empty.
REQ-014 SHALL have port dequeue_pc, output, 32 bits, head entry's aligned block address.
REQ-015 SHALL have port dequeue_inst, output, 32*FETCH_WIDTH bits, head entry's block data.
REQ-016 SHALL have port dequeue_valid, output, FETCH_WIDTH bits, head entry's valid lane mask.
REQ-017 SHALL have port flush, input, 1 bit, redirect fetch.
REQ-018 SHALL have port pc_new, input, 32 bits, redirect target.

Function
REQ-019 SHALL define B = 4*FETCH_WIDTH bytes; ufp_addr SHALL equal pc_r with its low log2(B) bits cleared.
REQ-020 SHALL use states IDLE, REQ, DRAIN, and WAIT (WAIT only when FETCH_HOLD_EN is defined).
REQ-021 SHALL issue a request when in IDLE, flush = 0, and the issue condition (REQ-033/034) holds: ufp_rmask all-ones for exactly that cycle, then go to REQ; ufp_rmask SHALL be 0 otherwise.
REQ-022 SHALL, in REQ on ufp_resp with flush = 0 and queue not full: enqueue {aligned pc_r, ufp_rdata, mask}, set pc_r to aligned pc_r + B, go to IDLE.
REQ-023 SHALL set valid mask bit i = 1 iff i >= pc_r[log2(B)-1:2], so an unaligned target invalidates lower lanes.
REQ-024 SHALL wrap pc_r arithmetic modulo 2^32.
REQ-025 SHALL make an entry visible at the dequeue outputs the cycle after enqueue; minimum request-to-request spacing is response latency + 1 cycle.
REQ-026 SHALL, on dequeue with is_empty = 0, pop the head; dequeue while empty SHALL be ignored; simultaneous enqueue and dequeue SHALL keep the count unchanged.
REQ-027 SHALL, on flush: load pc_r with pc_new, empty the queue, clear the hold register, and ignore dequeue in that cycle.
REQ-028 SHALL, on flush, move REQ without ufp_resp to DRAIN; REQ with ufp_resp to IDLE with data discarded; WAIT to IDLE; IDLE stays IDLE with no issue that cycle.
REQ-029 SHALL, in DRAIN, discard the response and go to IDLE on ufp_resp; a flush in DRAIN SHALL update pc_r and remain in DRAIN.
REQ-030 SHALL drive is_empty from a registered occupancy count (0..QUEUE_DEPTH) and use full = (count == QUEUE_DEPTH).

Reset
REQ-031 SHALL, on rst, set state IDLE, pc_r = PC_RESET, count 0, hold register cleared.
REQ-032 SHALL, during reset, drive ufp_rmask = 0 and is_empty = 1, and SHALL abandon any outstanding response; the first post-reset response in IDLE is ignored.

Configuration
REQ-033 SHALL, with FETCH_HOLD_EN undefined, issue only when not full, so a response always finds space and WAIT is unreachable.
REQ-034 SHALL, with FETCH_HOLD_EN defined, issue regardless of fullness; a response arriving while full is captured with its PC and mask into a hold register, pc_r advances, and the FSM goes to WAIT.
REQ-035 SHALL, in WAIT, enqueue the hold register in the first cycle the queue is not full, then go to IDLE.

Verification
REQ-036 SHALL test reset then immediate responses: FETCH_WIDTH = 2 gives entries at 1ECEB000, 1ECEB008, 1ECEB010, each with dequeue_valid = 2'b11.
REQ-037 SHALL test flush with pc_new = 0x1000_0004: the next entry has pc 0x1000_0000 and valid 2'b10, followed by 0x1000_0008.
REQ-038 SHALL test flush while in REQ with the response 3 cycles later: that response is dropped, and the first entry comes from pc_new.
REQ-039 SHALL test no dequeue for 40 cycles: the queue holds exactly 16 entries, no request is issued while full (hold disabled), and there is no overflow.
REQ-040 SHALL test FETCH_HOLD_EN with the queue full and a response arriving: it is held, then enqueued the cycle after one dequeue, with no entry lost.
REQ-041 SHALL test pc_new = 0xFFFF_FFF8: after that block, the next entry has pc 0x0000_0000.
